// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide sequencer.
// Optional feature macro: MD_EARLY_OUT_EN (see md_sequencer.sv).
package md_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } md_state_e;

endpackage

// File: rtl/md_sequencer_if.sv
// Core-side issue/result bundle of the multiply/divide sequencer.
// Optional feature macro: MD_EARLY_OUT_EN (see md_sequencer.sv).
interface md_sequencer_if #(
    parameter int WIDTH = 32
);
    import md_pkg::*;

    logic             start;
    md_op_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_rd;
    logic             busy;
    logic             stall;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hilo_rd,
        input  busy, stall, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, hilo_rd,
        output busy, stall, done, dbz, hi, lo
    );

endinterface

// File: rtl/md_addsub.sv
// Adder/subtractor with carry out, used for both step math and sign fix.
// Optional feature macro: MD_EARLY_OUT_EN (see md_sequencer.sv).
module md_addsub #(
    parameter int WIDTH = 33
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    assign {co, sum} = {1'b0, x} + {1'b0, y ^ {WIDTH{sub}}}
                     + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/md_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Optional feature macro: MD_EARLY_OUT_EN (early multiply exit).
module md_sequencer
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    md_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int AW = 2 * WIDTH + 1;

    md_state_e        state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    acc, acc_step, acc_calc;
    logic [WIDTH-1:0] opnd;
    logic             is_mul, neg_lo, neg_hi, div_zero;
    logic             done_q, dbz_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             signed_op, op_mul, b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             early, last;
    logic [WIDTH:0]   ls_x, ls_y, ls_sum, hs_x, hs_y, hs_sum;
    logic             ls_sub, hs_sub, ls_co, hs_co;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             unused_bits;

    assign signed_op = (bus.op == MD_MULT) || (bus.op == MD_DIV);
    assign op_mul    = (bus.op == MD_MULT) || (bus.op == MD_MULTU);
    assign b_zero    = !op_mul && (bus.b == '0);
    assign a_neg     = signed_op && bus.a[WIDTH-1];
    assign b_neg     = signed_op && bus.b[WIDTH-1];
    // A zero divisor keeps the raw dividend so it falls out as the remainder.
    assign a_mag     = (a_neg && !b_zero) ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;

    md_addsub #(.WIDTH(WIDTH + 1)) u_lo (
        .x(ls_x), .y(ls_y), .sub(ls_sub), .sum(ls_sum), .co(ls_co)
    );

    md_addsub #(.WIDTH(WIDTH + 1)) u_hi (
        .x(hs_x), .y(hs_y), .sub(hs_sub), .sum(hs_sum), .co(hs_co)
    );

    always_comb begin
        ls_x   = {1'b0, acc[2*WIDTH-1:WIDTH]};
        ls_y   = '0;
        ls_sub = 1'b0;
        hs_x   = '0;
        hs_y   = '0;
        hs_sub = 1'b0;
        if (state == S_FIX) begin
            ls_x   = '0;
            ls_y   = {1'b0, acc[WIDTH-1:0]};
            ls_sub = 1'b1;
            if (is_mul) begin
                // High word of a 2W negate: ~hi plus borrow out of low word.
                hs_x = {1'b0, ~acc[2*WIDTH-1:WIDTH]};
                hs_y = {{WIDTH{1'b0}}, ls_co};
            end else begin
                hs_y   = {1'b0, acc[2*WIDTH-1:WIDTH]};
                hs_sub = 1'b1;
            end
        end else if (is_mul) begin
            ls_x = acc[2*WIDTH:WIDTH];
            ls_y = acc[0] ? {1'b0, opnd} : '0;
        end else begin
            ls_x   = acc[2*WIDTH-1:WIDTH-1];
            ls_y   = {1'b0, opnd};
            ls_sub = 1'b1;
        end
    end

    always_comb begin
        acc_step = '0;
        if (is_mul) begin
            acc_step = {1'b0, ls_sum, acc[WIDTH-1:1]};
        end else begin
            acc_step = {1'b0, ls_co ? ls_sum[WIDTH-1:0] : ls_x[WIDTH-1:0],
                        acc[WIDTH-2:0], ls_co};
        end
    end

`ifdef MD_EARLY_OUT_EN
    logic [WIDTH-1:0] eo_mask;
    assign eo_mask  = (WIDTH'(1) << (cnt - CW'(1))) - WIDTH'(1);
    assign early    = is_mul && ((acc_step[WIDTH-1:0] & eo_mask) == '0);
    assign acc_calc = early ? acc_step >> (cnt - CW'(1)) : acc_step;
`else
    assign early    = 1'b0;
    assign acc_calc = acc_step;
`endif

    assign last        = (cnt == CW'(1)) || early;
    assign res_lo      = neg_lo ? ls_sum[WIDTH-1:0] : acc[WIDTH-1:0];
    assign res_hi      = neg_hi ? hs_sum[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
    assign unused_bits = ^{hs_co, hs_sum[WIDTH]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            state == S_IDLE: if (bus.start) state_nxt = S_CALC;
            state == S_CALC: if (last) state_nxt = S_FIX;
            state == S_FIX:  state_nxt = S_IDLE;
            default:         state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            is_mul   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    cnt      <= CW'(WIDTH);
                    opnd     <= op_mul ? a_mag : b_mag;
                    acc      <= {{(WIDTH + 1){1'b0}}, op_mul ? b_mag : a_mag};
                    is_mul   <= op_mul;
                    neg_lo   <= (a_neg ^ b_neg) && !b_zero;
                    neg_hi   <= op_mul ? (a_neg ^ b_neg) : (a_neg && !b_zero);
                    div_zero <= b_zero;
                    dbz_q    <= 1'b0;
                end
                S_CALC: begin
                    cnt <= cnt - CW'(1);
                    acc <= acc_calc;
                end
                S_FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                    dbz_q  <= div_zero;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == S_CALC) || (state == S_FIX);
    assign bus.stall = bus.busy && bus.hilo_rd;
    assign bus.done  = done_q;
    assign bus.dbz   = dbz_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Directed and random checks of md_sequencer against an arithmetic model.
// Latency expectations follow MD_EARLY_OUT_EN when it is defined.
module tb_md_sequencer;
    import md_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    md_sequencer_if #(.WIDTH(W)) bus ();

    md_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // {dbz, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [64:0] model(input md_op_e op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = '0;
        case (op)
            MD_MULT:  p = 64'(sa * sb);
            MD_MULTU: p = {32'b0, a} * {32'b0, b};
            MD_DIV: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
        return {1'b0, p};
    endfunction

    // Edges from accept to the done edge (= busy cycles).
    function automatic int latency(input md_op_e op, input logic [31:0] b);
        logic [31:0] m;
        int k;
        m = (op == MD_MULT && b[31]) ? -b : b;
        k = 0;
`ifdef MD_EARLY_OUT_EN
        if (op == MD_MULT || op == MD_MULTU) begin
            for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
            return ((k < 1) ? 1 : k) + 1;
        end
`endif
        return W + 1 + k - k;
    endfunction

    task automatic run_op(input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int pulse_at,
                          input int rd_at);
        logic [64:0] exp;
        logic [31:0] hold_hi, hold_lo;
        int lat, n, nbusy;
        bit hold_bad;
        exp = model(op, a, b);
        lat = latency(op, b);
        hold_hi = bus.hi;
        hold_lo = bus.lo;
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = $urandom;
        bus.b = $urandom;
        chk("dbz_at_accept", 64'(bus.dbz), 64'd0);
        nbusy = bus.busy ? 1 : 0;
        hold_bad = 1'b0;
        n = 0;
        while (n < 80) begin
            if (pulse_at != 0 && n + 1 == pulse_at) begin
                bus.start = 1'b1;
                bus.op = MD_DIVU;
                bus.a = $urandom;
                bus.b = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
            bus.start = 1'b0;
            if (bus.done) break;
            if (bus.busy) nbusy++;
            if (bus.hi !== hold_hi || bus.lo !== hold_lo) hold_bad = 1'b1;
            if (n == rd_at) begin
                bus.hilo_rd = 1'b1;
                #1;
                chk("stall_busy", 64'(bus.stall), 64'(n < lat));
                bus.hilo_rd = 1'b0;
            end
        end
        chk("done_latency", 64'(n), 64'(lat));
        chk("busy_cycles", 64'(nbusy), 64'(lat));
        chk("busy_in_done", 64'(bus.busy), 64'd0);
        chk("hilo_hold", 64'(hold_bad), 64'd0);
        chk("lo", 64'(bus.lo), 64'(exp[31:0]));
        chk("hi", 64'(bus.hi), 64'(exp[63:32]));
        chk("dbz", 64'(bus.dbz), 64'(exp[64]));
        bus.hilo_rd = 1'b1;
        #1;
        chk("stall_done", 64'(bus.stall), 64'd0);
        bus.hilo_rd = 1'b0;
    endtask

    initial begin
        int dones;
        md_op_e rop;
        logic [31:0] ra, rb;
        errors = 0;
        checks = 0;
        bus.start = 1'b0;
        bus.op = MD_MULT;
        bus.a = '0;
        bus.b = '0;
        bus.hilo_rd = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.hilo_rd = 1'b1;
        #1;
        chk("idle_stall", 64'(bus.stall), 64'd0);
        bus.hilo_rd = 1'b0;

        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(MD_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 0, 0);
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(MD_DIVU, 32'h0000_0005, 32'h0000_0000, 0, 0);
        run_op(MD_MULTU, 32'h0000_0002, 32'h0000_0003, 0, 0);
        run_op(MD_DIV, 32'hFFFF_FFF0, 32'h0000_0000, 0, 0);
        run_op(MD_MULTU, 32'h1234_5678, 32'hFFFF_FFFF, 5, 10);
        run_op(MD_MULTU, 32'h0000_0007, 32'h0000_0001, 0, 0);

        @(negedge clk);
        bus.start = 1'b1;
        bus.op = MD_MULTU;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_dbz", 64'(bus.dbz), 64'd0);
        chk("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        run_op(MD_DIVU, 32'd100, 32'd7, 0, 0);

        for (int i = 0; i < 24; i++) begin
            rop = md_op_e'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = 32'h0;
                1: rb = $urandom_range(1, 15);
                2: rb = -$urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            run_op(rop, ra, rb, 0, (i % 3 == 0) ? 3 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
